fifo_param: RTL and testbench

FIFO_PARAM -- requirements
Module: fifo_param

---
 rtl/fifo_param.sv | 171 +++++++++++++++++
 tb/tb_fifo_param.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// ---------------------------------------------------------------------------
// fifo_param -- single-clock parameterised packet FIFO with optional
// zero-latency bypass when empty.
//
// Parameters
//   WIDTH      packet width in bits (>= 1)
//   DEPTH      storage entries (>= 2, any value, not only powers of two)
//   AF_THRESH  almost_full asserts when occ >= AF_THRESH (1..DEPTH)
//   AE_THRESH  almost_empty asserts when occ <= AE_THRESH (0..DEPTH-1)
//   BYPASS     1: an empty FIFO forwards packet_in straight to packet_out
//
// Ports
//   clock        rising-edge clock for all state
//   reset_n      asynchronous active-low reset
//   flush        synchronous discard of all stored packets
//   in_valid     enqueue request
//   in_ready     FIFO can accept a packet this cycle
//   packet_in    enqueue data
//   out_valid    packet_out holds a valid packet
//   out_ready    consumer accepts packet_out this cycle
//   packet_out   dequeue data (zero whenever out_valid is low)
//   occ          registered stored-packet count
//   almost_full  occ >= AF_THRESH
//   almost_empty occ <= AE_THRESH
// ---------------------------------------------------------------------------
module fifo_param #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2,
   parameter int BYPASS    = 0
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           packet_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           packet_out,
   output logic [$clog2(DEPTH+1)-1:0] occ,
   output logic                       almost_full,
   output logic                       almost_empty
);

   localparam int OW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   localparam logic [OW-1:0] DEPTH_O = OW'(DEPTH);
   localparam logic [OW-1:0] AF_O    = OW'(AF_THRESH);
   localparam logic [OW-1:0] AE_O    = OW'(AE_THRESH);
   localparam logic [OW-1:0] ONE_O   = OW'(1);
   localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);
   localparam logic [PW-1:0] ONE_P   = PW'(1);
   localparam logic          BYP     = (BYPASS != 0);

   // Elaboration-time parameter range checks
   if (WIDTH < 1) begin : g_bad_width
      $error("fifo_param: WIDTH must be >= 1");
   end
   if (DEPTH < 2) begin : g_bad_depth
      $error("fifo_param: DEPTH must be >= 2");
   end
   if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("fifo_param: AF_THRESH must be in 1..DEPTH");
   end
   if (AE_THRESH < 0 || AE_THRESH >= DEPTH) begin : g_bad_ae
      $error("fifo_param: AE_THRESH must be in 0..DEPTH-1");
   end
   if (BYPASS != 0 && BYPASS != 1) begin : g_bad_byp
      $error("fifo_param: BYPASS must be 0 or 1");
   end

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [OW-1:0] occ_q,    occ_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   // Low through reset and until the first edge after release; holds the
   // input side (and the bypass path) closed during that window.
   logic          rdy_q,    rdy_d;

   logic byp_path;
   logic enq;
   logic deq;
   logic wr_en;
   logic rd_en;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_P) ? '0 : p + ONE_P;
   endfunction

   always_comb begin
      byp_path = BYP && (occ_q == '0);

      in_ready = rdy_q && (occ_q < DEPTH_O) && !flush;

      if (byp_path) begin
         out_valid = rdy_q && !flush && in_valid;
      end else begin
         out_valid = (occ_q != '0) && !flush;
      end

      enq = in_valid && in_ready;
      deq = out_valid && out_ready;

      // A bypassed packet that is consumed in the same cycle is never stored;
      // in bypass mode an empty FIFO has nothing to read from storage.
      wr_en = enq && !(byp_path && deq);
      rd_en = deq && !byp_path;

      if (!out_valid) begin
         packet_out = '0;
      end else if (byp_path) begin
         packet_out = packet_in;
      end else begin
         packet_out = mem_q[rd_ptr_q];
      end

      rdy_d    = 1'b1;
      occ_d    = occ_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;

      if (flush) begin
         occ_d    = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (wr_en) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
         end
         if (rd_en) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         if (wr_en && !rd_en) begin
            occ_d = occ_q + ONE_O;
         end else if (rd_en && !wr_en) begin
            occ_d = occ_q - ONE_O;
         end
      end

      occ          = occ_q;
      almost_full  = (occ_q >= AF_O);
      almost_empty = (occ_q <= AE_O);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         occ_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         rdy_q    <= 1'b0;
      end else begin
         occ_q    <= occ_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         rdy_q    <= rdy_d;
      end
   end

   // Storage needs no reset: occ gates out_valid, and packet_out is forced
   // to zero whenever out_valid is low, so stale entries are never visible.
   always_ff @(posedge clock) begin
      if (wr_en && !flush) begin
         mem_q[wr_ptr_q] <= packet_in;
      end
   end

endmodule

// File: tb/tb_fifo_param.sv
module tb_fifo_param;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic reset_n;

   int n_checks = 0;
   int n_errors = 0;

   // DUT A: DEPTH=16, defaults (AF=14, AE=2), no bypass
   logic       a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_af, a_ae;
   logic [7:0] a_packet_in, a_packet_out;
   logic [4:0] a_occ;

   // DUT B: DEPTH=5, AF=4, AE=1, no bypass
   logic       b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_af, b_ae;
   logic [7:0] b_packet_in, b_packet_out;
   logic [2:0] b_occ;

   // DUT C: DEPTH=4, bypass enabled (AF=2, AE=2)
   logic       c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_af, c_ae;
   logic [7:0] c_packet_in, c_packet_out;
   logic [2:0] c_occ;

   fifo_param #(.WIDTH(8), .DEPTH(16)) u_a (
      .clock(clock), .reset_n(reset_n), .flush(a_flush),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .packet_in(a_packet_in),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .packet_out(a_packet_out),
      .occ(a_occ), .almost_full(a_af), .almost_empty(a_ae)
   );

   fifo_param #(.WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1)) u_b (
      .clock(clock), .reset_n(reset_n), .flush(b_flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .packet_in(b_packet_in),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .packet_out(b_packet_out),
      .occ(b_occ), .almost_full(b_af), .almost_empty(b_ae)
   );

   fifo_param #(.WIDTH(8), .DEPTH(4), .BYPASS(1)) u_c (
      .clock(clock), .reset_n(reset_n), .flush(c_flush),
      .in_valid(c_in_valid), .in_ready(c_in_ready), .packet_in(c_packet_in),
      .out_valid(c_out_valid), .out_ready(c_out_ready), .packet_out(c_packet_out),
      .occ(c_occ), .almost_full(c_af), .almost_empty(c_ae)
   );

   logic [7:0] q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic enq_a(input logic [7:0] v);
      a_in_valid  = 1'b1;
      a_packet_in = v;
      a_out_ready = 1'b0;
      #1;
      check("a_enq_ready", 32'(a_in_ready), 32'd1);
      q.push_back(v);
      step();
      a_in_valid = 1'b0;
   endtask

   task automatic drain_a();
      for (int k = 0; k < 20 && q.size() > 0; k++) begin
         a_in_valid  = 1'b0;
         a_out_ready = 1'b1;
         #1;
         check("a_drain_valid", 32'(a_out_valid), 32'd1);
         check("a_drain_data", 32'(a_packet_out), 32'(q[0]));
         void'(q.pop_front());
         step();
         check("a_drain_occ", 32'(a_occ), 32'(q.size()));
         check("a_drain_ae", 32'(a_ae), 32'(q.size() <= 2));
         check("a_drain_af", 32'(a_af), 32'(q.size() >= 14));
      end
      a_out_ready = 1'b0;
      #1;
      check("a_empty_valid", 32'(a_out_valid), 32'd0);
      check("a_empty_data", 32'(a_packet_out), 32'd0);
      check("a_empty_ae", 32'(a_ae), 32'd1);
   endtask

   initial begin
      int m_occ, p, c;
      logic exp_ir, exp_ov, enq, deq;

      reset_n = 1'b0;
      {a_flush, a_in_valid, a_out_ready, a_packet_in} = '0;
      {b_flush, b_in_valid, b_out_ready, b_packet_in} = '0;
      {c_flush, c_in_valid, c_out_ready, c_packet_in} = '0;

      // Reset state
      #1;
      check("rst_occ", 32'(a_occ), 32'd0);
      check("rst_in_ready", 32'(a_in_ready), 32'd0);
      check("rst_out_valid", 32'(a_out_valid), 32'd0);
      check("rst_packet_out", 32'(a_packet_out), 32'd0);
      check("rst_af", 32'(a_af), 32'd0);
      check("rst_ae", 32'(a_ae), 32'd1);
      #1 reset_n = 1'b1;
      #1;
      check("rst_ready_pre_edge", 32'(a_in_ready), 32'd0);
      step();
      check("rst_ready_post_edge", 32'(a_in_ready), 32'd1);

      // Fill DEPTH=16 with 0..15, consumer stalled
      for (int i = 0; i < 16; i++) begin
         enq_a(8'(i));
         check("a_fill_occ", 32'(a_occ), 32'(i + 1));
         check("a_fill_af", 32'(a_af), 32'(i + 1 >= 14));
         check("a_fill_ae", 32'(a_ae), 32'(i + 1 <= 2));
      end
      // 17th request refused
      a_in_valid = 1'b1; a_packet_in = 8'd99; a_out_ready = 1'b0;
      #1;
      check("a_full_ready", 32'(a_in_ready), 32'd0);
      step();
      check("a_full_occ", 32'(a_occ), 32'd16);
      // Full and dequeuing: input still refused
      a_in_valid = 1'b1; a_packet_in = 8'd99; a_out_ready = 1'b1;
      #1;
      check("a_full_deq_ready", 32'(a_in_ready), 32'd0);
      check("a_full_deq_data", 32'(a_packet_out), 32'(q[0]));
      void'(q.pop_front());
      step();
      check("a_full_deq_occ", 32'(a_occ), 32'd15);
      // Simultaneous at DEPTH-1
      a_in_valid = 1'b1; a_packet_in = 8'd100; a_out_ready = 1'b1;
      #1;
      check("a_d1_ready", 32'(a_in_ready), 32'd1);
      check("a_d1_data", 32'(a_packet_out), 32'(q[0]));
      void'(q.pop_front());
      q.push_back(8'd100);
      step();
      check("a_d1_occ", 32'(a_occ), 32'd15);
      drain_a();

      // Simultaneous at occ==1
      enq_a(8'd7);
      a_in_valid = 1'b1; a_packet_in = 8'd8; a_out_ready = 1'b1;
      #1;
      check("a_o1_data", 32'(a_packet_out), 32'd7);
      void'(q.pop_front());
      q.push_back(8'd8);
      step();
      check("a_o1_occ", 32'(a_occ), 32'd1);
      drain_a();

      // Flush at occ=7 with both handshakes requested
      for (int i = 0; i < 7; i++) enq_a(8'(10 + i));
      check("a_pre_flush_occ", 32'(a_occ), 32'd7);
      a_flush = 1'b1; a_in_valid = 1'b1; a_packet_in = 8'hEE; a_out_ready = 1'b1;
      #1;
      check("a_flush_ready", 32'(a_in_ready), 32'd0);
      check("a_flush_valid", 32'(a_out_valid), 32'd0);
      check("a_flush_data", 32'(a_packet_out), 32'd0);
      step();
      a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
      q.delete();
      #1;
      check("a_post_flush_occ", 32'(a_occ), 32'd0);
      check("a_post_flush_valid", 32'(a_out_valid), 32'd0);
      enq_a(8'd55);
      drain_a();

      // DEPTH=5 streaming with stalls against a bench occupancy model
      m_occ = 0; p = 0; c = 0;
      for (int cyc = 0; cyc < 600 && c < 40; cyc++) begin
         b_in_valid  = (p < 40) && (cyc % 5 != 2);
         b_packet_in = 8'(p);
         b_out_ready = (cyc % 20 < 8) ? 1'b0 : (cyc % 3 != 0);
         #1;
         exp_ir = (m_occ < 5);
         exp_ov = (m_occ > 0);
         check("b_in_ready", 32'(b_in_ready), 32'(exp_ir));
         check("b_out_valid", 32'(b_out_valid), 32'(exp_ov));
         check("b_packet_out", 32'(b_packet_out), exp_ov ? 32'(8'(c)) : 32'd0);
         enq = b_in_valid && exp_ir;
         deq = exp_ov && b_out_ready;
         step();
         if (enq) begin p++; m_occ++; end
         if (deq) begin c++; m_occ--; end
         check("b_occ", 32'(b_occ), 32'(m_occ));
         check("b_af", 32'(b_af), 32'(m_occ >= 4));
         check("b_ae", 32'(b_ae), 32'(m_occ <= 1));
      end
      if (c != 40) begin
         n_checks++; n_errors++;
         $display("FAIL b_stream_timeout: got %0d expected 40", c);
      end
      b_in_valid = 1'b0; b_out_ready = 1'b0;

      // Bypass DUT
      c_in_valid = 1'b0; c_out_ready = 1'b1;
      #1;
      check("c_idle_valid", 32'(c_out_valid), 32'd0);
      check("c_idle_data", 32'(c_packet_out), 32'd0);
      c_in_valid = 1'b1; c_packet_in = 8'hA5; c_out_ready = 1'b1;
      #1;
      check("c_byp_valid", 32'(c_out_valid), 32'd1);
      check("c_byp_data", 32'(c_packet_out), 32'hA5);
      step();
      check("c_byp_occ", 32'(c_occ), 32'd0);
      c_in_valid = 1'b1; c_packet_in = 8'h3C; c_out_ready = 1'b0;
      #1;
      check("c_stall_data", 32'(c_packet_out), 32'h3C);
      step();
      check("c_stored_occ", 32'(c_occ), 32'd1);
      c_in_valid = 1'b1; c_packet_in = 8'h11; c_out_ready = 1'b1;
      #1;
      check("c_order_data", 32'(c_packet_out), 32'h3C);
      step();
      check("c_order_occ", 32'(c_occ), 32'd1);
      c_in_valid = 1'b0; c_out_ready = 1'b1;
      #1;
      check("c_second_data", 32'(c_packet_out), 32'h11);
      step();
      check("c_final_occ", 32'(c_occ), 32'd0);
      check("c_final_valid", 32'(c_out_valid), 32'd0);
      c_out_ready = 1'b0;

      // Asynchronous reset at occ=9, between edges
      for (int i = 0; i < 9; i++) enq_a(8'(20 + i));
      check("a_pre_rst_occ", 32'(a_occ), 32'd9);
      #2 reset_n = 1'b0;
      #1;
      check("a_mid_rst_occ", 32'(a_occ), 32'd0);
      check("a_mid_rst_ready", 32'(a_in_ready), 32'd0);
      check("a_mid_rst_valid", 32'(a_out_valid), 32'd0);
      check("a_mid_rst_data", 32'(a_packet_out), 32'd0);
      check("a_mid_rst_af", 32'(a_af), 32'd0);
      check("a_mid_rst_ae", 32'(a_ae), 32'd1);
      #1 reset_n = 1'b1;
      q.delete();
      step();
      check("a_post_rst_ready", 32'(a_in_ready), 32'd1);
      enq_a(8'd77);
      drain_a();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
